motor_mixer: RTL and testbench



---
 rtl/motor_mixer.sv | 162 ++++++++++++++++
 tb/tb_motor_mixer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_mixer.sv
// motor_mixer: mixes throttle/pitch/roll/yaw into NUM_MOTORS duty values with arming,
// spin-up ramp and command watchdog. Define MOTOR_MIXER_SLEW_EN for per-sample slew limiting.
module motor_mixer #(
  parameter int                      WIDTH          = 8,
  parameter int                      NUM_MOTORS     = 4,
  parameter logic [3*NUM_MOTORS-1:0] MIX_SIGNS      = 12'b011_001_111_101,
  parameter logic [WIDTH-1:0]        IDLE_DUTY      = 8'h32,
  parameter logic [WIDTH-1:0]        MAX_DUTY       = 8'h64,
  parameter int                      SPINUP_STEP    = 1,
  parameter int                      SPINUP_DIV     = 1000,
  parameter int                      TIMEOUT_CYCLES = 50000
`ifdef MOTOR_MIXER_SLEW_EN
  , parameter logic [WIDTH-1:0]      SLEW_MAX       = 8'h04
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            throttle,
  input  logic [WIDTH-1:0]            pitch,
  input  logic [WIDTH-1:0]            roll,
  input  logic [WIDTH-1:0]            yaw,
  input  logic                        arm_req,
  output logic [NUM_MOTORS*WIDTH-1:0] duty,
  output logic                        out_valid,
  output logic                        armed,
  output logic                        timeout_flag
);

  localparam int SW    = WIDTH + 3;
  localparam int DIV_W = $clog2(SPINUP_DIV + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [SW-1:0] IDLE_S = $signed({3'b000, IDLE_DUTY});
  localparam logic signed [SW-1:0] MAX_S  = $signed({3'b000, MAX_DUTY});

  typedef enum logic [1:0] {DISARMED = 2'd0, SPINUP = 2'd1, ARMED = 2'd2} state_t;

  state_t                      state_q;
  logic [WIDTH-1:0]            ramp_q;
  logic [DIV_W-1:0]            div_q;
  logic [TO_W-1:0]             wdog_q;
  logic                        timeout_flag_q;
  logic                        out_valid_q;
  logic                        s1_valid_q;
  logic [NUM_MOTORS*WIDTH-1:0] duty_q;
  logic [NUM_MOTORS*WIDTH-1:0] stage2_d;
  logic [WIDTH:0]              ramp_sum;
  logic [WIDTH-1:0]            ramp_d;
  logic                        cap_en;

  assign ramp_sum = {1'b0, ramp_q} + (WIDTH+1)'(SPINUP_STEP);
  assign ramp_d   = (ramp_sum >= {1'b0, IDLE_DUTY}) ? IDLE_DUTY : ramp_sum[WIDTH-1:0];
  // A sample entering stage 1 implies the watchdog cannot fire this cycle.
  assign cap_en   = (state_q == ARMED) && arm_req && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_motor
      logic signed [SW-1:0] pitch_s, roll_s, yaw_s, sum_d, s1_sum_q;
      logic [WIDTH-1:0]     clamp_w;

      assign pitch_s = $signed({{3{pitch[WIDTH-1]}}, pitch});
      assign roll_s  = $signed({{3{roll[WIDTH-1]}}, roll});
      assign yaw_s   = $signed({{3{yaw[WIDTH-1]}}, yaw});
      assign sum_d   = $signed({3'b000, throttle}) + IDLE_S
                     + (MIX_SIGNS[3*gi+2] ? pitch_s : -pitch_s)
                     + (MIX_SIGNS[3*gi+1] ? roll_s  : -roll_s)
                     + (MIX_SIGNS[3*gi]   ? yaw_s   : -yaw_s);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_sum_q <= '0;
        end else if (cap_en) begin
          s1_sum_q <= sum_d;
        end
      end

      assign clamp_w = (s1_sum_q < IDLE_S) ? IDLE_DUTY :
                       (s1_sum_q > MAX_S)  ? MAX_DUTY  : s1_sum_q[WIDTH-1:0];

`ifdef MOTOR_MIXER_SLEW_EN
      logic [WIDTH-1:0] prev_w;
      assign prev_w = duty_q[gi*WIDTH +: WIDTH];
      // Previous duty is IDLE_DUTY on ARMED entry because the ramp ends there.
      assign stage2_d[gi*WIDTH +: WIDTH] =
          (clamp_w > prev_w && (clamp_w - prev_w) > SLEW_MAX) ? prev_w + SLEW_MAX :
          (prev_w > clamp_w && (prev_w - clamp_w) > SLEW_MAX) ? prev_w - SLEW_MAX : clamp_w;
`else
      assign stage2_d[gi*WIDTH +: WIDTH] = clamp_w;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= DISARMED;
      ramp_q         <= '0;
      div_q          <= '0;
      wdog_q         <= '0;
      timeout_flag_q <= 1'b0;
      out_valid_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      duty_q         <= '0;
    end else begin
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      if (!arm_req) timeout_flag_q <= 1'b0;
      case (state_q)
        DISARMED: begin
          duty_q <= '0;
          if (arm_req && !timeout_flag_q) begin
            state_q <= SPINUP;
            ramp_q  <= '0;
            div_q   <= '0;
          end
        end
        SPINUP: begin
          if (!arm_req) begin
            state_q <= DISARMED;
            duty_q  <= '0;
          end else if (ramp_q == IDLE_DUTY) begin
            state_q <= ARMED;
            wdog_q  <= '0;
          end else if (div_q == DIV_W'(SPINUP_DIV - 1)) begin
            div_q  <= '0;
            ramp_q <= ramp_d;
            duty_q <= {NUM_MOTORS{ramp_d}};
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ARMED: begin
          if (!arm_req) begin
            state_q <= DISARMED;
            duty_q  <= '0;
          end else if (!in_valid && wdog_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q        <= DISARMED;
            duty_q         <= '0;
            timeout_flag_q <= 1'b1;
          end else begin
            wdog_q     <= in_valid ? '0 : wdog_q + TO_W'(1);
            s1_valid_q <= in_valid;
            if (s1_valid_q) begin
              duty_q      <= stage2_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= DISARMED;
          duty_q  <= '0;
        end
      endcase
    end
  end

  assign duty         = duty_q;
  assign out_valid    = out_valid_q;
  assign armed        = (state_q == ARMED);
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_motor_mixer.sv
// tb_motor_mixer: randomized stimulus against a cycle-level behavioural model of the mixer
// (arming, spin-up formula, watchdog, mixing arithmetic on plain integers).
module tb_motor_mixer;

  localparam int          W    = 8;
  localparam int          N    = 4;
  localparam int          MW   = N * W;
  localparam logic [11:0] MIX  = 12'b011_001_111_101;
  localparam int          IDLE = 50;
  localparam int          MAXD = 100;
  localparam int          STEP = 1;
  localparam int          DIV  = 4;
  localparam int          TO   = 16;
`ifdef MOTOR_MIXER_SLEW_EN
  localparam int          SLEW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          arm_req = 1'b0;
  logic [W-1:0]  throttle = '0, pitch = '0, roll = '0, yaw = '0;
  logic [MW-1:0] duty;
  logic          out_valid, armed, timeout_flag;

  motor_mixer #(
    .WIDTH(W), .NUM_MOTORS(N), .MIX_SIGNS(MIX), .IDLE_DUTY(8'h32), .MAX_DUTY(8'h64),
    .SPINUP_STEP(STEP), .SPINUP_DIV(DIV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .throttle(throttle), .pitch(pitch),
    .roll(roll), .yaw(yaw), .arm_req(arm_req), .duty(duty), .out_valid(out_valid),
    .armed(armed), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 0 = disarmed, 1 = spinning up, 2 = armed.
  int            m_state = 0;
  int            m_n = 0;
  int            m_quiet = 0;
  int            cyc = 0;
  int            txn = 0;
  bit            m_flag = 1'b0;
  bit            m_ov = 1'b0;
  logic [MW-1:0] m_duty = '0;
  int            due_q[$];
  logic [MW-1:0] val_q[$];

  function automatic int sx(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int sgn(input int k, input int b);
    return MIX[3*k+b] ? 1 : -1;
  endfunction

  function automatic int ramp_at(input int n);
    int r;
    r = (n / DIV) * STEP;
    return (r > IDLE) ? IDLE : r;
  endfunction

  function automatic logic [MW-1:0] fill(input int v);
    logic [MW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [MW-1:0] mix_target(input logic [7:0] t, input logic [7:0] p,
                                               input logic [7:0] r, input logic [7:0] y);
    logic [MW-1:0] res;
    int s;
    for (int k = 0; k < N; k++) begin
      s = int'(t) + IDLE + sgn(k, 2) * sx(p) + sgn(k, 1) * sx(r) + sgn(k, 0) * sx(y);
      if (s < IDLE) s = IDLE;
      if (s > MAXD) s = MAXD;
      res[k*W +: W] = W'(s);
    end
    return res;
  endfunction

  task automatic leave_armed();
    m_state = 0;
    m_duty  = '0;
    due_q.delete();
    val_q.delete();
  endtask

  // Advances the model across the clock edge that just happened, using the inputs it sampled.
  task automatic model_step();
    logic [MW-1:0] v;
    m_ov = 1'b0;
    cyc++;
    case (m_state)
      0: begin
        m_duty = '0;
        if (!arm_req) m_flag = 1'b0;
        if (arm_req && !m_flag) begin
          m_state = 1;
          m_n = 0;
        end
      end
      1: begin
        if (!arm_req) begin
          leave_armed();
        end else if (ramp_at(m_n) == IDLE) begin
          m_state = 2;
          m_quiet = 0;
          due_q.delete();
          val_q.delete();
        end else begin
          m_n++;
          m_duty = fill(ramp_at(m_n));
        end
      end
      default: begin
        if (!arm_req) begin
          leave_armed();
        end else begin
          m_quiet = in_valid ? 0 : m_quiet + 1;
          if (m_quiet == TO) begin
            leave_armed();
            m_flag = 1'b1;
          end else begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
              void'(due_q.pop_front());
              v = val_q.pop_front();
`ifdef MOTOR_MIXER_SLEW_EN
              for (int k = 0; k < N; k++) begin
                int tg, pv;
                tg = int'(v[k*W +: W]);
                pv = int'(m_duty[k*W +: W]);
                if (tg > pv + SLEW) tg = pv + SLEW;
                else if (tg < pv - SLEW) tg = pv - SLEW;
                v[k*W +: W] = W'(tg);
              end
`endif
              m_duty = v;
              m_ov = 1'b1;
              txn++;
              $display("txn %0d: duty=%h expected=%h out_valid=%b", txn, duty, m_duty, out_valid);
            end
            if (in_valid) begin
              due_q.push_back(cyc + 1);
              val_q.push_back(mix_target(throttle, pitch, roll, yaw));
            end
          end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("duty", 64'(duty), 64'(m_duty));
    check_eq("out_valid", 64'(out_valid), 64'(m_ov));
    check_eq("armed", 64'(armed), 64'(m_state == 2));
    check_eq("timeout_flag", 64'(timeout_flag), 64'(m_flag));
  endtask

  task automatic drive(input bit iv, input bit arm, input logic [7:0] t, input logic [7:0] p,
                       input logic [7:0] r, input logic [7:0] y);
    in_valid = iv;
    arm_req  = arm;
    throttle = t;
    pitch    = p;
    roll     = r;
    yaw      = y;
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int phase, pc, gap;
    bit iv;
    phase = 0;
    pc = 0;
    gap = 0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    for (int it = 0; it < 3000 && phase < 8; it++) begin
      @(posedge clk);
      #1;
      model_step();
      check_outputs();

      case (phase)
        0: if (pc >= 4)          begin phase = 1; pc = 0; end
        1: if (m_state == 2)     begin phase = 2; pc = 0; end
        2: if (pc >= 150)        begin phase = 3; pc = 0; end
        3: if (pc >= 30)         begin phase = 4; pc = 0; end
        4: if (pc >= 1)          begin phase = 5; pc = 0; end
        5: if (m_state == 2)     begin phase = 6; pc = 0; end
        6: if (pc >= 5)          begin phase = 7; pc = 0; end
        7: if (pc >= 30)         begin phase = 8; pc = 0; end
        default: ;
      endcase

      case (phase)
        0: drive($urandom_range(0, 1) == 1, 1'b0, rnd8(), rnd8(), rnd8(), rnd8());
        1, 5, 7: drive($urandom_range(0, 1) == 1, 1'b1, rnd8(), rnd8(), rnd8(), rnd8());
        2: begin
          if (pc == 0)      drive(1'b1, 1'b1, 8'h10, 8'h00, 8'h00, 8'h00);
          else if (pc == 1) drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
          else if (pc == 2) drive(1'b1, 1'b1, 8'h20, 8'h08, 8'hFC, 8'h02);
          else if (pc == 3) drive(1'b1, 1'b1, 8'h40, 8'h7F, 8'h00, 8'h00);
          else begin
            iv = (gap >= 8) || ($urandom_range(0, 2) != 0);
            drive(iv, 1'b1, rnd8(), rnd8(), rnd8(), rnd8());
          end
        end
        3: drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        4: drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        6: begin
          if (pc == 0)      drive(1'b1, 1'b1, 8'h30, 8'h10, 8'h00, 8'h00);
          else if (pc == 1) drive(1'b1, 1'b0, 8'h50, 8'h00, 8'h00, 8'h00);
          else              drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        end
        default: drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      endcase
      gap = in_valid ? 0 : gap + 1;
      pc++;
    end
    check_eq("scenario_complete", 64'(phase), 64'(8));

    // Asynchronous reset in the middle of a ramp, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_duty", 64'(duty), 64'(0));
    check_eq("async_rst_armed", 64'(armed), 64'(0));
    check_eq("async_rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("async_rst_flag", 64'(timeout_flag), 64'(0));
    #20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
